// File: rtl/aes128_byte_loader.sv
// Byte-stream input stage for aes128_encryption. Assembles a 128-bit key and a 128-bit plaintext block and offers them under a valid/ready block handshake.
// Optional completed-block counter: define AES_LOADER_CNT_EN.
module aes128_byte_loader #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_byte,
  input  logic         in_is_key,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [0:127] plaintext,
  output logic [0:127] key,
  output logic         key_loaded,
  output logic         blk_valid,
  input  logic         blk_ready
`ifdef AES_LOADER_CNT_EN
  ,
  output logic [CNT_W-1:0] blk_count
`endif
);

  // Handshakes: a byte moves on a rising edge with in_valid & in_ready;
  // a block moves on a rising edge with blk_valid & blk_ready.
  logic [4:0] kcnt;
  logic [4:0] dcnt;
  logic       byte_acc;
  logic       blk_hs;

  assign in_ready = !blk_valid && (in_is_key || (dcnt != 5'd16));
  assign byte_acc = in_valid && in_ready;
  assign blk_hs   = blk_valid && blk_ready;

  // kcnt[3:0] is 0 both after reset and once all 16 key bytes are in,
  // so it is the write slot in every case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plaintext  <= '0;
      key        <= '0;
      key_loaded <= 1'b0;
      blk_valid  <= 1'b0;
      kcnt       <= 5'd0;
      dcnt       <= 5'd0;
    end else begin
      if (byte_acc) begin
        if (in_is_key) begin
          key[{kcnt[3:0], 3'b000} +: 8] <= in_byte;
          kcnt       <= (kcnt == 5'd16) ? 5'd1 : kcnt + 5'd1;
          key_loaded <= (kcnt == 5'd15);
        end else begin
          plaintext[{dcnt[3:0], 3'b000} +: 8] <= in_byte;
          dcnt <= dcnt + 5'd1;
        end
      end
      if (blk_hs) begin
        blk_valid <= 1'b0;
        dcnt      <= 5'd0;
      end else if ((dcnt == 5'd16) && key_loaded) begin
        blk_valid <= 1'b1;
      end
    end
  end

`ifdef AES_LOADER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count <= '0;
    end else if (blk_hs) begin
      blk_count <= blk_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes128_byte_loader.sv
// Self-checking bench for aes128_byte_loader: vector table, directed corner sequences and random traffic against a byte-array reference model.
module tb_aes128_byte_loader;

  logic         clk;
  logic         rst_n;
  logic [7:0]   in_byte;
  logic         in_is_key;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] plaintext;
  logic [0:127] key;
  logic         key_loaded;
  logic         blk_valid;
  logic         blk_ready;
`ifdef AES_LOADER_CNT_EN
  logic [15:0]  blk_count;
`endif

  aes128_byte_loader #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_byte    (in_byte),
    .in_is_key  (in_is_key),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .key_loaded (key_loaded),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready)
`ifdef AES_LOADER_CNT_EN
    ,
    .blk_count  (blk_count)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int failures;

  // reference model: byte slots and counters
  logic [7:0] mk[16];
  logic [7:0] mp[16];
  int         m_kn;
  int         m_dn;
  bit         m_kl;
  bit         m_bv;
  int         m_cnt;

  typedef struct {
    logic [127:0] k;
    logic [127:0] p;
  } vec_t;
  vec_t tbl[3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] m_key();
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], mk[i]};
    return v;
  endfunction

  function automatic logic [127:0] m_pt();
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], mp[i]};
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mk[i] = 8'h00;
      mp[i] = 8'h00;
    end
    m_kn = 0; m_dn = 0; m_kl = 0; m_bv = 0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("key", key, m_key());
    chk("plaintext", plaintext, m_pt());
    chk("key_loaded", key_loaded, m_kl);
    chk("blk_valid", blk_valid, m_bv);
`ifdef AES_LOADER_CNT_EN
    chk("blk_count", blk_count, m_cnt & 16'hffff);
`endif
  endtask

  // driver: one clock cycle with the given inputs, model stepped in parallel
  task automatic step(input bit v, input bit isk, input logic [7:0] b, input bit rdy);
    bit mr, acc, hs, setv;
    in_valid = v; in_is_key = isk; in_byte = b; blk_ready = rdy;
    #1;
    mr = !m_bv && (isk || m_dn != 16);
    chk("in_ready", in_ready, mr);
    acc  = v && mr;
    hs   = m_bv && rdy;
    setv = !m_bv && (m_dn == 16) && m_kl;
    @(posedge clk);
    if (acc) begin
      if (isk) begin
        if (m_kn == 0 || m_kn == 16) begin
          mk[0] = b; m_kn = 1; m_kl = 0;
        end else begin
          mk[m_kn] = b; m_kn++;
          if (m_kn == 16) m_kl = 1;
        end
      end else begin
        mp[m_dn] = b; m_dn++;
      end
    end
    if (hs) begin
      m_bv = 0; m_dn = 0; m_cnt++;
    end else if (setv) begin
      m_bv = 1;
    end
    #1;
    check_outputs();
  endtask

  task automatic send16(input bit isk, input logic [127:0] v);
    for (int i = 0; i < 16; i++) step(1'b1, isk, v[127 - 8*i -: 8], 1'b0);
  endtask

  task automatic hard_reset();
    in_valid = 0; in_is_key = 0; in_byte = 0; blk_ready = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_key", key, 128'h0);
    chk("rst_plaintext", plaintext, 128'h0);
    chk("rst_key_loaded", key_loaded, 1'b0);
    chk("rst_blk_valid", blk_valid, 1'b0);
`ifdef AES_LOADER_CNT_EN
    chk("rst_blk_count", blk_count, 16'h0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [127:0] save_k, save_p;
  int           cnt0;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1;
    in_valid = 0; in_is_key = 0; in_byte = 0; blk_ready = 0;
    model_reset();
    @(posedge clk);
    #1;
    hard_reset();

    tbl[0].k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    tbl[0].p = 128'h3243f6a8885a308d313198a2e0370734;
    tbl[1].k = 128'h000102030405060708090a0b0c0d0e0f;
    tbl[1].p = 128'h00112233445566778899aabbccddeeff;
    tbl[2].k = 128'hffeeddccbbaa99887766554433221100;
    tbl[2].p = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    // vector table: key then plaintext, one cycle latency, handshake
    for (int t = 0; t < 3; t++) begin
      send16(1'b1, tbl[t].k);
      chk("tbl_key_loaded", key_loaded, 1'b1);
      send16(1'b0, tbl[t].p);
      chk("tbl_valid_early", blk_valid, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("tbl_valid", blk_valid, 1'b1);
      chk("tbl_key", key, tbl[t].k);
      chk("tbl_plaintext", plaintext, tbl[t].p);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("tbl_valid_clear", blk_valid, 1'b0);
      chk("tbl_key_kept", key_loaded, 1'b1);
    end

    // data before key
    hard_reset();
    send16(1'b0, tbl[0].p);
    in_valid = 1; in_is_key = 0; in_byte = 8'h55; #1;
    chk("dbk_in_ready", in_ready, 1'b0);
    step(1'b1, 1'b0, 8'h55, 1'b0);
    chk("dbk_plaintext", plaintext, tbl[0].p);
    send16(1'b1, tbl[0].k);
    chk("dbk_valid_early", blk_valid, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("dbk_valid", blk_valid, 1'b1);

    // backpressure: 10 cycles held, offered bytes refused
    save_k = key; save_p = plaintext;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i[0], 8'($urandom_range(0, 255)), 1'b0);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_key", key, save_k);
      chk("bp_plaintext", plaintext, save_p);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("bp_valid_clear", blk_valid, 1'b0);
    chk("bp_key_loaded", key_loaded, 1'b1);

    // key reuse: two blocks, no key bytes
    cnt0 = m_cnt;
    for (int r = 0; r < 2; r++) begin
      send16(1'b0, tbl[r+1].p);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("reuse_valid", blk_valid, 1'b1);
      chk("reuse_key", key, tbl[0].k);
      chk("reuse_plaintext", plaintext, tbl[r+1].p);
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
`ifdef AES_LOADER_CNT_EN
    chk("reuse_count", blk_count, 16'(cnt0 + 2));
`endif

    // key replacement
    step(1'b1, 1'b1, 8'h00, 1'b0);
    chk("krep_loaded", key_loaded, 1'b0);
    chk("krep_byte0", key[0:7], 8'h00);
    for (int i = 1; i < 16; i++) step(1'b1, 1'b1, 8'(i * 17), 1'b0);
    chk("krep_loaded_again", key_loaded, 1'b1);

    // reset mid-operation, then full reload reproduces vector 0
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    hard_reset();
    send16(1'b1, tbl[0].k);
    send16(1'b0, tbl[0].p);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rl_valid", blk_valid, 1'b1);
    chk("rl_key", key, tbl[0].k);
    chk("rl_plaintext", plaintext, tbl[0].p);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           8'($urandom_range(0, 255)), $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes128_byte_loader.md
Name: aes128_byte_loader

Overview:
Upstream input stage for aes128_encryption. Accepts an 8-bit byte stream with a valid/ready handshake and assembles 16 key bytes and 16 plaintext bytes into 128-bit registers. Presents `key` and `plaintext` to the combinational core, held stable under a valid/ready block handshake. The key is retained across blocks, so several plaintext blocks can be loaded under one key.

Parameters:
CNT_W, 16, width of optional completed-block counter (used only with AES_LOADER_CNT_EN).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_byte  input  8  stream byte
in_is_key  input  1  1 = in_byte is a key byte, 0 = plaintext byte; qualified by in_valid
in_valid  input  1  upstream byte valid
in_ready  output  1  loader can accept the offered byte
plaintext  output  [0:127]  assembled plaintext to aes128_encryption
key  output  [0:127]  assembled key to aes128_encryption
key_loaded  output  1  all 16 bytes of the current key are present
blk_valid  output  1  plaintext and key are complete and stable
blk_ready  input  1  consumer has taken the block (encdata captured)
blk_count  output  CNT_W  completed block handshakes (AES_LOADER_CNT_EN only)

Behaviour:
- Reset, asynchronous on rst_n low, clears all of the following to 0:
  - plaintext, key, key_loaded, blk_valid
  - the internal 5-bit key byte count kcnt and data byte count dcnt (range 0..16)
  - blk_count
- Byte acceptance happens on a rising clk edge with in_valid & in_ready. No other event loads a byte.
- Byte ordering: the first byte accepted lands in bits [0:7], the n-th byte in bits [8n-8 : 8n-1] (MSB-first, FIPS-197 order).
- Key path:
  - Accepting a key byte while kcnt==16 or kcnt==0 starts a new key:
    - key_loaded clears in that same cycle.
    - The byte is written to key[0:7] and kcnt becomes 1.
    - The unwritten key bytes keep their old values; don't-care.
  - Accepting a key byte with 0<kcnt<16 writes it to slot kcnt and increments kcnt.
  - When kcnt reaches 16, key_loaded is set on that edge.
- Data path:
  - Accepting a data byte with dcnt<16 writes it to slot dcnt and increments dcnt.
- in_ready is combinational: in_ready = !blk_valid && (in_is_key || dcnt!=16).
  - Key bytes can be accepted while a full data block waits for its key.
  - No byte is accepted while blk_valid is high.
- Block valid:
  - blk_valid is registered. It is set on the edge after both dcnt==16 and key_loaded hold.
  - Latency: 1 cycle after the last required byte is accepted.
  - blk_valid stays high, with plaintext and key frozen, until blk_valid & blk_ready at a rising edge.
  - On that handshake edge: blk_valid clears, dcnt clears to 0, key and key_loaded are retained.
  - New bytes are accepted from the next cycle.
- blk_ready while blk_valid is low is ignored.
- Simultaneous events:
  - The last data byte and the last key byte can never share an edge (one byte per cycle).
  - A handshake edge and a byte-accept edge are mutually exclusive, because in_ready=0 while blk_valid=1.
- Reset mid-load: all partial bytes are discarded, and the next byte of each type lands in slot 0.
- Every output except in_ready is registered.

Optional Feature:
AES_LOADER_CNT_EN.
- Defined:
  - The blk_count port exists.
  - It increments by 1 on each blk_valid & blk_ready edge and wraps from 2^CNT_W-1 to 0.
  - It is cleared by reset.
- Undefined: the blk_count port and its logic are absent, and all other behaviour is identical.

Test Plan:
- FIPS-197 vector:
  - Stimulus: key bytes 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c, then plaintext bytes 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34, blk_ready=1.
  - Response:
    - key=2b7e151628aed2a6abf7158809cf4f3c and plaintext=3243f6a8885a308d313198a2e0370734.
    - blk_valid high one cycle after the last byte.
    - Core encdata=3925841d02dc09fbdc118597196a0b32.
- Data before key:
  - Stimulus: 16 plaintext bytes first, then a data byte offered with in_is_key=0.
  - Response: in_ready=0 and dcnt stays 16.
  - Stimulus: then 16 key bytes.
  - Response: blk_valid rises one cycle after the 16th key byte.
- Backpressure:
  - Stimulus: hold blk_ready=0 for 10 cycles after blk_valid, with in_valid=1 throughout.
  - Response: in_ready=0, and plaintext and key unchanged for all 10 cycles.
  - Stimulus: release blk_ready=1.
  - Response: blk_valid=0 next cycle, key_loaded stays 1.
- Key reuse: two consecutive plaintext blocks under one key → two handshakes with no key bytes resent; blk_count=2 when AES_LOADER_CNT_EN is defined.
- Key replacement: after a full key, send one new key byte 00 → key_loaded=0 and key[0:7]=00; after 15 further bytes, key_loaded=1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously after 7 data bytes and 5 key bytes.
  - Response: all outputs 0 immediately.
  - Stimulus: a full reload.
  - Response: vector 1 results reproduced exactly.
